// File: rtl/tx_stream_arbiter_pkg.sv
// Shared definitions for the UART transmit stream arbiter.
package tx_stream_arbiter_pkg;

  // State encoding doubles as the one-hot grant vector (IDLE=00, OWN0=01, OWN1=10).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam int REQ_KB  = 0;
  localparam int REQ_RSP = 1;

  // 10 ms of idle time at 12 MHz before a locked grant is forced open.
  localparam int LOCK_TIMEOUT_12MHZ = 120000;

  function automatic arb_state_e own_state(input logic req);
    return (req == 1'(REQ_RSP)) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/tx_stream_arbiter_if.sv
// Stream signals of the arbiter: two byte sources in, one UART stream out.
interface tx_stream_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              i_kb_valid;
  logic [DATA_W-1:0] i_kb_data;
  logic              i_kb_last;
  logic              o_kb_ready;

  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;
  logic              i_rsp_last;
  logic              o_rsp_ready;

  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  logic [1:0]        o_grant;
  logic              o_timeout;

  modport slave (
    input  i_kb_valid, i_kb_data, i_kb_last,
    input  i_rsp_valid, i_rsp_data, i_rsp_last,
    input  i_ready,
    output o_kb_ready, o_rsp_ready,
    output o_valid, o_data, o_grant, o_timeout
  );

  modport master (
    output i_kb_valid, i_kb_data, i_kb_last,
    output i_rsp_valid, i_rsp_data, i_rsp_last,
    output i_ready,
    input  o_kb_ready, o_rsp_ready,
    input  o_valid, o_data, o_grant, o_timeout
  );
endinterface

// File: rtl/tx_stream_arbiter_axis_out_reg.sv
// Single-entry stream holding register; reusable output stage for stream muxes.
module axis_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_slot_free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Slot is free when empty or being drained this cycle; a load refills it in the same cycle.
  always_comb begin
    o_slot_free = !valid_q || i_ready;
    valid_d     = valid_q;
    data_d      = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Holding register; reset discards any pending byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/tx_stream_arbiter.sv
// Round-robin arbiter sharing the UART transmit stream between the keyboard
// translator (req0) and the terminal response source (req1). A grant is held
// for a whole sequence (until last) or until the idle timeout fires.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no owner, readies low, picks next owner
// ST_OWN0 | keyboard translator owns the channel
// ST_OWN1 | response source owns the channel
module tx_stream_arbiter
  import tx_stream_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_12MHZ,
  parameter int DATA_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  tx_stream_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  // Releasing on the idle cycle that brings the count to LOCK_TIMEOUT-1 puts
  // the o_timeout pulse exactly LOCK_TIMEOUT cycles after the last accept.
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(LOCK_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              slot_free;
  logic              kb_acc, rsp_acc, acc, acc_last;
  logic [DATA_W-1:0] acc_data;

  // Accept strobes and the byte being loaded into the output register.
  always_comb begin
    kb_acc   = (state_q == ST_OWN0) && bus.i_kb_valid  && slot_free;
    rsp_acc  = (state_q == ST_OWN1) && bus.i_rsp_valid && slot_free;
    acc      = kb_acc || rsp_acc;
    acc_data = rsp_acc ? bus.i_rsp_data : bus.i_kb_data;
    acc_last = rsp_acc ? bus.i_rsp_last : bus.i_kb_last;
  end

  // Next-state, priority pointer and idle counter.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_kb_valid && bus.i_rsp_valid) state_d = own_state(ptr_q);
        else if (bus.i_kb_valid)               state_d = ST_OWN0;
        else if (bus.i_rsp_valid)              state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (acc) begin
          cnt_d = '0;
          if (acc_last) begin
            state_d = ST_IDLE;
            ptr_d   = (state_q == ST_OWN0);
          end
        end else if (cnt_q == CNT_HIT) begin
          state_d   = ST_IDLE;
          ptr_d     = (state_q == ST_OWN0);
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration state register; priority restarts at the keyboard source.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'(REQ_KB);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  axis_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (acc),
    .i_data      (acc_data),
    .i_ready     (bus.i_ready),
    .o_valid     (bus.o_valid),
    .o_data      (bus.o_data),
    .o_slot_free (slot_free)
  );

  assign bus.o_kb_ready  = (state_q == ST_OWN0) && slot_free;
  assign bus.o_rsp_ready = (state_q == ST_OWN1) && slot_free;
  assign bus.o_grant     = state_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed bench for tx_stream_arbiter with LOCK_TIMEOUT=16.
module tb_tx_stream_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   hold_rsp_chk = 0;

  logic [7:0] out_q[$];
  time        out_t[$];

  tx_stream_arbiter_if #(.DATA_W(8)) bus ();

  tx_stream_arbiter #(.LOCK_TIMEOUT(16), .DATA_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // record every byte the UART takes
  always @(posedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      out_q.push_back(bus.o_data);
      out_t.push_back($time);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_kb_valid = 0;  bus.i_kb_data = 0;  bus.i_kb_last = 0;
    bus.i_rsp_valid = 0; bus.i_rsp_data = 0; bus.i_rsp_last = 0;
    bus.i_ready = 1;
    repeat (2) @(negedge clk);
    out_q.delete();
    out_t.delete();
    rst = 1'b0;
  endtask

  // Present one byte and hold it until accepted (bounded); returns on the next negedge.
  task automatic push(input bit which, input logic [7:0] d, input bit l);
    int n = 0;
    bit got = 0;
    if (which) begin
      bus.i_rsp_valid = 1; bus.i_rsp_data = d; bus.i_rsp_last = l;
    end else begin
      bus.i_kb_valid = 1;  bus.i_kb_data = d;  bus.i_kb_last = l;
    end
    while (!got && n < 50) begin
      #1;
      got = which ? bus.o_rsp_ready : bus.o_kb_ready;
      if (!which && hold_rsp_chk) check_val("rsp_ready_held_off", 32'(bus.o_rsp_ready), 0);
      @(negedge clk);
      n++;
    end
    check_val("push_accepted", 32'(got), 1);
    if (which) bus.i_rsp_valid = 0;
    else       bus.i_kb_valid  = 0;
  endtask

  // count cycles from the accept cycle until o_timeout (bounded)
  task automatic wait_timeout(output int delta);
    delta = 1;
    while (delta < 40) begin
      #1;
      if (bus.o_timeout) break;
      @(negedge clk);
      delta++;
    end
  endtask

  initial begin
    int   delta;
    int   n;
    bit   early;
    int   ord[$];
    int   exp_ord[4] = '{0, 1, 0, 1};
    logic [7:0] exp2[4] = '{8'h1B, 8'h5B, 8'h41, 8'h52};
    logic [7:0] exp3[4] = '{8'h10, 8'h20, 8'h10, 8'h20};

    // ---- reset state and test 1: single byte from req0
    do_reset();
    #1;
    check_val("rst_valid", 32'(bus.o_valid), 0);
    check_val("rst_data", 32'(bus.o_data), 0);
    check_val("rst_grant", 32'(bus.o_grant), 0);
    check_val("rst_timeout", 32'(bus.o_timeout), 0);
    check_val("rst_kb_ready", 32'(bus.o_kb_ready), 0);
    check_val("rst_rsp_ready", 32'(bus.o_rsp_ready), 0);
    bus.i_kb_valid = 1; bus.i_kb_data = 8'h41; bus.i_kb_last = 1;
    check_val("t1_c0_kb_ready", 32'(bus.o_kb_ready), 0);
    @(negedge clk); #1;
    check_val("t1_c1_grant", 32'(bus.o_grant), 1);
    check_val("t1_c1_kb_ready", 32'(bus.o_kb_ready), 1);
    check_val("t1_c1_valid", 32'(bus.o_valid), 0);
    @(negedge clk);
    bus.i_kb_valid = 0;
    #1;
    check_val("t1_c2_valid", 32'(bus.o_valid), 1);
    check_val("t1_c2_data", 32'(bus.o_data), 'h41);
    check_val("t1_c2_grant", 32'(bus.o_grant), 0);
    @(negedge clk); #1;
    check_val("t1_c3_valid", 32'(bus.o_valid), 0);

    // ---- test 2: req0 escape sequence with req1 pending throughout
    do_reset();
    bus.i_rsp_valid = 1; bus.i_rsp_data = 8'h52; bus.i_rsp_last = 1;
    hold_rsp_chk = 1;
    push(0, 8'h1B, 0);
    push(0, 8'h5B, 0);
    push(0, 8'h41, 1);
    hold_rsp_chk = 0;
    push(1, 8'h52, 1);
    repeat (3) @(negedge clk);
    check_val("t2_count", out_q.size(), 4);
    if (out_q.size() == 4)
      for (int i = 0; i < 4; i++) check_val("t2_byte", 32'(out_q[i]), 32'(exp2[i]));

    // ---- test 3: simultaneous requests, round-robin
    do_reset();
    bus.i_kb_valid = 1;  bus.i_kb_data = 8'h10;  bus.i_kb_last = 1;
    bus.i_rsp_valid = 1; bus.i_rsp_data = 8'h20; bus.i_rsp_last = 1;
    n = 0;
    while (ord.size() < 4 && n < 30) begin
      #1;
      if (bus.o_kb_ready)  ord.push_back(0);
      if (bus.o_rsp_ready) ord.push_back(1);
      @(negedge clk);
      n++;
    end
    bus.i_kb_valid = 0; bus.i_rsp_valid = 0;
    repeat (3) @(negedge clk);
    check_val("t3_grants", ord.size(), 4);
    if (ord.size() == 4)
      for (int i = 0; i < 4; i++) check_val("t3_order", ord[i], exp_ord[i]);
    check_val("t3_count", out_q.size(), 4);
    if (out_q.size() == 4)
      for (int i = 0; i < 4; i++) check_val("t3_byte", 32'(out_q[i]), 32'(exp3[i]));

    // ---- test 4: UART stall for 5 cycles mid-sequence
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, 8'hA0 + 8'(i), (i == 5));
      end
      begin
        repeat (3) @(negedge clk);
        bus.i_ready = 0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check_val("t4_stall_valid", 32'(bus.o_valid), 1);
          check_val("t4_stall_data", 32'(bus.o_data), 'hA1);
          check_val("t4_stall_kb_ready", 32'(bus.o_kb_ready), 0);
          @(negedge clk);
        end
        bus.i_ready = 1;
      end
    join
    repeat (3) @(negedge clk);
    check_val("t4_count", out_q.size(), 6);
    if (out_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check_val("t4_byte", 32'(out_q[i]), 'hA0 + i);
      check_val("t4_stall_gap", 32'(out_t[1] - out_t[0]), 60);
      check_val("t4_throughput", 32'(out_t[5] - out_t[2]), 30);
    end

    // ---- test 5a: idle timeout hands the channel to req1
    do_reset();
    bus.i_rsp_valid = 1; bus.i_rsp_data = 8'h52; bus.i_rsp_last = 1;
    push(0, 8'h1B, 0);
    wait_timeout(delta);
    check_val("t5_timeout_delay", delta, 16);
    check_val("t5_grant_at_pulse", 32'(bus.o_grant), 0);
    @(negedge clk); #1;
    check_val("t5_pulse_width", 32'(bus.o_timeout), 0);
    check_val("t5_next_grant", 32'(bus.o_grant), 2);
    push(1, 8'h52, 1);
    repeat (2) @(negedge clk);
    check_val("t5_count", out_q.size(), 2);
    if (out_q.size() == 2) check_val("t5_rsp_byte", 32'(out_q[1]), 'h52);

    // ---- test 5b: accept on the last idle cycle keeps the lock
    do_reset();
    bus.i_rsp_valid = 1; bus.i_rsp_data = 8'h52; bus.i_rsp_last = 1;
    push(0, 8'h1B, 0);
    early = 0;
    for (int c = 2; c < 16; c++) begin
      #1;
      if (bus.o_timeout) early = 1;
      @(negedge clk);
    end
    check_val("t5b_no_early_pulse", 32'(early), 0);
    bus.i_kb_valid = 1; bus.i_kb_data = 8'h5B; bus.i_kb_last = 0;
    #1;
    check_val("t5b_late_accept", 32'(bus.o_kb_ready), 1);
    @(negedge clk);
    bus.i_kb_valid = 0;
    #1;
    check_val("t5b_no_pulse", 32'(bus.o_timeout), 0);
    check_val("t5b_still_owned", 32'(bus.o_grant), 1);
    @(negedge clk);
    wait_timeout(delta);
    check_val("t5b_timeout_delay", delta + 1, 16);
    bus.i_rsp_valid = 0;

    // ---- test 6: reset while a byte is held in OWN1
    do_reset();
    push(0, 8'h11, 1);
    push(1, 8'h77, 0);
    bus.i_ready = 0;
    #1;
    check_val("t6_held_valid", 32'(bus.o_valid), 1);
    check_val("t6_held_grant", 32'(bus.o_grant), 2);
    rst = 1;
    @(negedge clk); #1;
    check_val("t6_rst_valid", 32'(bus.o_valid), 0);
    check_val("t6_rst_grant", 32'(bus.o_grant), 0);
    check_val("t6_rst_data", 32'(bus.o_data), 0);
    rst = 0;
    bus.i_ready = 1;
    bus.i_kb_valid = 1;  bus.i_kb_data = 8'h33;  bus.i_kb_last = 1;
    bus.i_rsp_valid = 1; bus.i_rsp_data = 8'h44; bus.i_rsp_last = 1;
    @(negedge clk); #1;
    check_val("t6_priority_kb", 32'(bus.o_grant), 1);
    bus.i_kb_valid = 0; bus.i_rsp_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
